// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network post-processing blocks: data width,
// pooled map sizes per layer, the layer select encoding and a counter-width helper.
package bnn_pkg;

    localparam int DATA_W    = 32;
    localparam int POOL0_DIM = 12;
    localparam int POOL1_DIM = 4;
    localparam int PIX0_DEF  = POOL0_DIM * POOL0_DIM;
    localparam int PIX1_DEF  = POOL1_DIM * POOL1_DIM;

    typedef enum logic {
        LAYER0 = 1'b0,
        LAYER1 = 1'b1
    } layer_e;

    // Width of a counter that must hold 0 .. n_pix-1 (never narrower than 1 bit).
    function automatic int pix_cnt_w(input int n_pix);
        if (n_pix <= 2) begin
            return 1;
        end else begin
            return $clog2(n_pix);
        end
    endfunction

endpackage : bnn_pkg

// File: rtl/bin_act_pack_bit_packer.sv
// bit_packer: collects one activation bit per valid cycle LSB-first into a
// PACK_W-bit word. A word is emitted (registered, one cycle later) when it is
// full or when the current bit closes the frame; a partial word is emitted with
// its unfilled upper bits at zero. The accumulator clears in the emit cycle so a
// new word can start on the very next valid bit.
module bit_packer #(
    parameter int PACK_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    input  logic              i_bit,
    input  logic              i_last,
    output logic              o_valid,
    output logic [PACK_W-1:0] o_word,
    output logic              o_last
);

    localparam int BC_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(PACK_W - 1);

    logic [PACK_W-1:0] r_shift;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              r_valid;
    logic [PACK_W-1:0] r_word;
    logic              r_last;

    logic [PACK_W-1:0] w_onehot;
    logic [PACK_W-1:0] w_word;
    logic              w_full;
    logic              w_emit;

    // Merge the incoming bit into the accumulator and decide whether the word closes.
    always_comb begin
        w_onehot = {PACK_W{1'b0}};
        w_word   = r_shift;
        w_full   = 1'b0;
        w_emit   = 1'b0;
        if (i_valid) begin
            w_onehot = {{(PACK_W-1){1'b0}}, i_bit} << r_bit_cnt;
            w_word   = r_shift | w_onehot;
            w_full   = (r_bit_cnt == BC_FULL);
            w_emit   = w_full | i_last;
        end else begin
            w_onehot = {PACK_W{1'b0}};
            w_word   = r_shift;
            w_full   = 1'b0;
            w_emit   = 1'b0;
        end
    end

    // Accumulator, bit position and registered word/strobe outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift   <= {PACK_W{1'b0}};
            r_bit_cnt <= {BC_W{1'b0}};
            r_valid   <= 1'b0;
            r_word    <= {PACK_W{1'b0}};
            r_last    <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_last  <= w_emit & i_last;
            if (w_emit) begin
                r_word    <= w_word;
                r_shift   <= {PACK_W{1'b0}};
                r_bit_cnt <= {BC_W{1'b0}};
            end else if (i_valid) begin
                r_shift   <= w_word;
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end else begin
                r_shift   <= r_shift;
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_last  = r_last;

endmodule : bit_packer

// File: rtl/bin_act_pack.sv
// bin_act_pack: sign activation (folded batch-norm threshold) of pooled values
// followed by LSB-first bit packing into PACK_W-bit words, with per-layer frame
// tracking and zero-padded flush of the final word of each frame.
//
// Optional feature macro: BN_THRESH_EN
//   defined   -> per-layer threshold registers written through thr_we/thr_sel/thr_din
//   undefined -> both layers compare against the constant THR_RST; thr_* are unused
module bin_act_pack
    import bnn_pkg::*;
#(
    parameter int                         PACK_W  = 16,
    parameter int                         PIX_L0  = PIX0_DEF,
    parameter int                         PIX_L1  = PIX1_DEF,
    parameter logic signed [DATA_W-1:0]   THR_RST = 32'sd0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              state,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] din,
    input  logic              thr_we,
    input  logic              thr_sel,
    input  logic [DATA_W-1:0] thr_din,
    output logic              ovalid,
    output logic [PACK_W-1:0] dout,
    output logic              frame_done
);

    localparam int PIX_MAX = (PIX_L0 > PIX_L1) ? PIX_L0 : PIX_L1;
    localparam int CNT_W   = pix_cnt_w(PIX_MAX);
    localparam logic [CNT_W-1:0] LAST_L0 = CNT_W'(PIX_L0 - 1);
    localparam logic [CNT_W-1:0] LAST_L1 = CNT_W'(PIX_L1 - 1);

    logic [CNT_W-1:0]         r_pix_cnt;
    layer_e                   r_layer;

    logic                     w_frame_start;
    layer_e                   w_layer;
    logic signed [DATA_W-1:0] w_thr0;
    logic signed [DATA_W-1:0] w_thr1;
    logic signed [DATA_W-1:0] w_thr;
    logic                     w_bit;
    logic                     w_last;

`ifdef BN_THRESH_EN
    logic signed [DATA_W-1:0] r_thr0;
    logic signed [DATA_W-1:0] r_thr1;

    // Per-layer thresholds; a write lands at the clock edge, so a pixel in the same
    // cycle still compares against the previous value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_thr0 <= THR_RST;
            r_thr1 <= THR_RST;
        end else if (thr_we) begin
            if (thr_sel == LAYER1) begin
                r_thr1 <= $signed(thr_din);
            end else begin
                r_thr0 <= $signed(thr_din);
            end
        end else begin
            r_thr0 <= r_thr0;
            r_thr1 <= r_thr1;
        end
    end

    assign w_thr0 = r_thr0;
    assign w_thr1 = r_thr1;
`else
    logic w_unused_thr;

    assign w_thr0       = THR_RST;
    assign w_thr1       = THR_RST;
    assign w_unused_thr = ^{thr_we, thr_sel, thr_din};
`endif

    // Layer in force for this pixel (freshly sampled on a frame's first pixel),
    // its threshold, the activation bit and the end-of-frame flag.
    always_comb begin
        w_frame_start = (r_pix_cnt == {CNT_W{1'b0}});
        if (w_frame_start) begin
            w_layer = layer_e'(state);
        end else begin
            w_layer = r_layer;
        end

        case (w_layer)
            LAYER0: begin
                w_thr  = w_thr0;
                w_last = (r_pix_cnt == LAST_L0);
            end
            LAYER1: begin
                w_thr  = w_thr1;
                w_last = (r_pix_cnt == LAST_L1);
            end
            default: begin
                w_thr  = w_thr0;
                w_last = 1'b0;
            end
        endcase

        w_bit = ($signed(din) >= w_thr);
    end

    // Frame position and latched layer; both advance only on valid pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pix_cnt <= {CNT_W{1'b0}};
            r_layer   <= LAYER0;
        end else if (ivalid) begin
            r_layer <= w_layer;
            if (w_last) begin
                r_pix_cnt <= {CNT_W{1'b0}};
            end else begin
                r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end
        end else begin
            r_pix_cnt <= r_pix_cnt;
            r_layer   <= r_layer;
        end
    end

    bit_packer #(
        .PACK_W (PACK_W)
    ) u_bit_packer (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (ivalid),
        .i_bit   (w_bit),
        .i_last  (w_last),
        .o_valid (ovalid),
        .o_word  (dout),
        .o_last  (frame_done)
    );

endmodule : bin_act_pack

// File: tb/tb_bin_act_pack.sv
// Self-checking bench for bin_act_pack: a 16-bit and a 32-bit packing instance
// share one stimulus stream; a behavioural model pushes expected words (with the
// cycle they must appear) into per-instance queues, and outputs are popped and
// compared one time unit after each rising edge.
module tb_bin_act_pack;
    import bnn_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        state;
    logic        ivalid;
    logic [31:0] din;
    logic        thr_we;
    logic        thr_sel;
    logic [31:0] thr_din;

    logic        ov16, fd16, ov32, fd32;
    logic [15:0] do16;
    logic [31:0] do32;

    always #5 clk = ~clk;

    bin_act_pack #(.PACK_W(16)) dut (
        .clk(clk), .rstn(rstn), .state(state), .ivalid(ivalid), .din(din),
        .thr_we(thr_we), .thr_sel(thr_sel), .thr_din(thr_din),
        .ovalid(ov16), .dout(do16), .frame_done(fd16)
    );

    bin_act_pack #(.PACK_W(32)) dut32 (
        .clk(clk), .rstn(rstn), .state(state), .ivalid(ivalid), .din(din),
        .thr_we(thr_we), .thr_sel(thr_sel), .thr_din(thr_din),
        .ovalid(ov32), .dout(do32), .frame_done(fd32)
    );

    typedef struct {
        logic [31:0] word;
        logic        fd;
        int          cyc;
    } exp_t;

    exp_t        q16[$];
    exp_t        q32[$];
    logic [15:0] obs16[$];
    logic [15:0] ref16[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_w16, n_fd16, n_w32, n_fd32;
    logic [15:0] last16;
    logic [31:0] last32;

    int                 m_pix;
    logic               m_layer;
    logic [31:0]        m_acc16, m_acc32;
    int                 m_bc16, m_bc32;
    logic signed [31:0] m_thr0, m_thr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pix   = 0;
        m_layer = 1'b0;
        m_acc16 = 32'h0;
        m_acc32 = 32'h0;
        m_bc16  = 0;
        m_bc32  = 0;
        m_thr0  = 32'sd0;
        m_thr1  = 32'sd0;
        q16.delete();
        q32.delete();
    endtask

    task automatic model_pix(input logic [31:0] d, input logic st);
        logic signed [31:0] thr;
        logic b;
        logic last;
        int   npix;
        exp_t e;
        if (m_pix == 0) m_layer = st;
        thr  = m_layer ? m_thr1 : m_thr0;
        b    = ($signed(d) >= thr);
        npix = m_layer ? 16 : 144;
        last = (m_pix == npix - 1);
        m_acc16[m_bc16] = b;
        m_bc16++;
        if (m_bc16 == 16 || last) begin
            e.word = m_acc16; e.fd = last; e.cyc = cyc + 1;
            q16.push_back(e);
            m_acc16 = 32'h0; m_bc16 = 0;
        end
        m_acc32[m_bc32] = b;
        m_bc32++;
        if (m_bc32 == 32 || last) begin
            e.word = m_acc32; e.fd = last; e.cyc = cyc + 1;
            q32.push_back(e);
            m_acc32 = 32'h0; m_bc32 = 0;
        end
        m_pix = last ? 0 : m_pix + 1;
    endtask

    task automatic clear_counts();
        n_w16 = 0; n_fd16 = 0; n_w32 = 0; n_fd32 = 0;
        obs16.delete();
    endtask

    task automatic check_outputs();
        exp_t e;
        if (ov16) begin
            n_w16++;
            if (fd16) n_fd16++;
            last16 = do16;
            obs16.push_back(do16);
            if (q16.size() == 0) begin
                chk("ovalid16_unexpected", {31'b0, ov16}, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("dout16", {16'h0, do16}, {16'h0, e.word[15:0]});
                chk("frame_done16", {31'b0, fd16}, {31'b0, e.fd});
                chk("latency16", cyc, e.cyc);
            end
        end else begin
            chk("frame_done16_no_ovalid", {31'b0, fd16}, 32'd0);
            if (q16.size() > 0 && q16[0].cyc <= cyc) begin
                chk("ovalid16_missing", {31'b0, ov16}, 32'd1);
                void'(q16.pop_front());
            end
        end
        if (ov32) begin
            n_w32++;
            if (fd32) n_fd32++;
            last32 = do32;
            if (q32.size() == 0) begin
                chk("ovalid32_unexpected", {31'b0, ov32}, 32'd0);
            end else begin
                e = q32.pop_front();
                chk("dout32", do32, e.word);
                chk("frame_done32", {31'b0, fd32}, {31'b0, e.fd});
                chk("latency32", cyc, e.cyc);
            end
        end else begin
            chk("frame_done32_no_ovalid", {31'b0, fd32}, 32'd0);
            if (q32.size() > 0 && q32[0].cyc <= cyc) begin
                chk("ovalid32_missing", {31'b0, ov32}, 32'd1);
                void'(q32.pop_front());
            end
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic st,
                        input logic we, input logic sel, input logic [31:0] td);
        ivalid  = iv;
        din     = d;
        state   = st;
        thr_we  = we;
        thr_sel = sel;
        thr_din = td;
        if (iv && rstn) model_pix(d, st);
`ifdef BN_THRESH_EN
        if (we && rstn) begin
            if (sel) m_thr1 = td;
            else     m_thr0 = td;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic pix(input logic [31:0] d, input logic st);
        step(1'b1, d, st, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, state, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] frame_data[144];

        rstn = 1'b0; state = 1'b0; ivalid = 1'b0; din = 32'h0;
        thr_we = 1'b0; thr_sel = 1'b0; thr_din = 32'h0;
        model_reset();
        clear_counts();
        #12;
        chk("reset_ovalid16", {31'b0, ov16}, 32'd0);
        chk("reset_dout16", {16'h0, do16}, 32'd0);
        chk("reset_frame_done16", {31'b0, fd16}, 32'd0);
        chk("reset_ovalid32", {31'b0, ov32}, 32'd0);
        chk("reset_dout32", do32, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: layer0, alternating +5/-5 -> nine 16'h5555 words.
        clear_counts();
        for (int i = 0; i < 144; i++) begin
            d = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFB;
            pix(d, 1'b0);
        end
        idle(3);
        chk("t1_words16", n_w16, 32'd9);
        chk("t1_fd16", n_fd16, 32'd1);
        chk("t1_last16", {16'h0, last16}, 32'h0000_5555);
        chk("t1_words32", n_w32, 32'd5);

        // Test 2: layer1, all -1 except pixel 3 = 0 -> single word 16'h0008.
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            d = (i == 3) ? 32'h0 : 32'hFFFF_FFFF;
            pix(d, 1'b1);
        end
        idle(2);
        chk("t2_words16", n_w16, 32'd1);
        chk("t2_fd16", n_fd16, 32'd1);
        chk("t2_word16", {16'h0, last16}, 32'h0000_0008);
        chk("t2_word32", last32, 32'h0000_0008);

        // Test 3: all 7 on layer0 -> 32-bit instance gives 4 full words + 16'hFFFF tail.
        clear_counts();
        for (int i = 0; i < 144; i++) pix(32'd7, 1'b0);
        idle(2);
        chk("t3_words32", n_w32, 32'd5);
        chk("t3_fd32", n_fd32, 32'd1);
        chk("t3_last32", last32, 32'h0000_FFFF);
        chk("t3_words16", n_w16, 32'd9);

        // Test 4: threshold write coincident with a pixel; the pixel uses the old value.
        clear_counts();
        step(1'b1, 32'd100, 1'b1, 1'b1, 1'b1, 32'd100);
        pix(32'd99, 1'b1);
        for (int i = 0; i < 14; i++) pix(32'hFFFF_FFFF, 1'b1);
        idle(2);
        chk("t4_words16", n_w16, 32'd1);
`ifdef BN_THRESH_EN
        chk("t4_word16", {16'h0, last16}, 32'h0000_0001);
`else
        chk("t4_word16", {16'h0, last16}, 32'h0000_0003);
`endif

        // Test 5: random data gapless, then again with random gaps and a mid-frame
        // state toggle; the packed words must be identical.
        for (int i = 0; i < 144; i++) frame_data[i] = $urandom();
        clear_counts();
        for (int i = 0; i < 144; i++) pix(frame_data[i], 1'b0);
        idle(2);
        ref16 = obs16;
        clear_counts();
        for (int i = 0; i < 144; i++) begin
            if ($urandom_range(1) == 1) idle(1);
            pix(frame_data[i], (i >= 50) ? 1'b1 : 1'b0);
        end
        idle(2);
        chk("t5_words16", n_w16, 32'd9);
        chk("t5_fd16", n_fd16, 32'd1);
        chk("t5_words32", n_w32, 32'd5);
        chk("t5_ref_len", ref16.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < obs16.size() && i < ref16.size())
                chk("t5_gap_vs_gapless", {16'h0, obs16[i]}, {16'h0, ref16[i]});
        end

        // Test 6: reset mid-frame discards the partial word; a fresh frame follows.
        clear_counts();
        for (int i = 0; i < 10; i++) pix($urandom(), 1'b0);
        rstn = 1'b0;
        model_reset();
        idle(3);
        chk("t6_ovalid_in_reset", {31'b0, ov16}, 32'd0);
        rstn = 1'b1;
        idle(1);
        chk("t6_words_after_partial", n_w16, 32'd0);
        clear_counts();
        for (int i = 0; i < 144; i++) pix($urandom(), 1'b0);
        idle(3);
        chk("t6_words16", n_w16, 32'd9);
        chk("t6_fd16", n_fd16, 32'd1);
        chk("t6_words32", n_w32, 32'd5);

        chk("final_q16_empty", q16.size(), 32'd0);
        chk("final_q32_empty", q32.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bin_act_pack
